// File: rtl/ram8_bank.sv
// Eight-entry WIDTH-bit register bank with demuxed write enables, combinational
// read select and a self-timed clear sweep that zeroes one entry per cycle.
module ram8_bank #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic [2:0]       address,
    input  logic             clear,
    output logic [WIDTH-1:0] out,
    output logic             busy,
    output logic             done
);

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t           state, next_state;
    logic [2:0]       ptr;
    logic [WIDTH-1:0] mem [8];
    logic [7:0]       load_en;
    logic [7:0]       zero_en;
    logic             sweep_last;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            ptr   <= 3'd0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            done  <= sweep_last;
            if (state == IDLE && clear)
                ptr <= 3'd0;
            else if (state == SWEEP)
                ptr <= ptr + 3'd1;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (clear) next_state = SWEEP;
            SWEEP:   if (ptr == 3'd7) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Normal writes only happen in IDLE; during a sweep the only enable is the pointer's entry.
    always_comb begin
        busy       = (state == SWEEP);
        sweep_last = (state == SWEEP) && (ptr == 3'd7);
        load_en    = 8'd0;
        zero_en    = 8'd0;
        if (state == IDLE && load)
            load_en[address] = 1'b1;
        if (state == SWEEP)
            zero_en[ptr] = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 8; i++)
                mem[i] <= '0;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (zero_en[i])
                    mem[i] <= '0;
                else if (load_en[i])
                    mem[i] <= in;
            end
        end
    end

    assign out = mem[address];

endmodule

// File: tb/tb_ram8_bank.sv
// Directed self-checking bench for ram8_bank: reset, write/readback,
// read-during-write, clear sweep timing, sweep corner cases and reset mid-sweep.
module tb_ram8_bank;

    logic        clk;
    logic        reset;
    logic [15:0] in;
    logic        load;
    logic [2:0]  address;
    logic        clear;
    logic [15:0] out;
    logic        busy;
    logic        done;

    int checks;
    int errors;

    ram8_bank #(.WIDTH(16)) dut (
        .clk     (clk),
        .reset   (reset),
        .in      (in),
        .load    (load),
        .address (address),
        .clear   (clear),
        .out     (out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [15:0] d);
        address = a;
        in      = d;
        load    = 1'b1;
        tick();
        load    = 1'b0;
    endtask

    task automatic fill_all();
        logic [15:0] v;
        for (int i = 0; i < 8; i++) begin
            v = 16'(16'h1111 * (i + 1));
            write_word(3'(i), v);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in = '0; load = 0; address = 0; clear = 0;
        tick(); tick();
        #3 reset = 1'b0;
        tick();
        write_word(3'd1, 16'h5A5A);
        address = 3'd1;
        #1;
        checks++;
        if (out !== 16'h5A5A) begin
            errors++; $display("[TB] FAIL pre_reset_write out=%h expected=%h", out, 16'h5A5A);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (out !== 16'h0000 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL async_reset out=%h busy=%b done=%b expected 0000/0/0", out, busy, done);
        end
        tick();
        #2 reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++; $display("[TB] FAIL reset_read addr=%0d out=%h expected=0000", i, out);
            end
        end
    endtask

    task automatic test_write_read();
        logic [15:0] model [8];
        logic [15:0] v;
        for (int i = 0; i < 8; i++) model[i] = 16'h0000;
        for (int i = 0; i < 8; i++) begin
            v = 16'(16'h1111 * (i + 1));
            write_word(3'(i), v);
            model[i] = v;
            for (int j = 0; j < 8; j++) begin
                address = 3'(j);
                #1;
                checks++;
                if (out !== model[j]) begin
                    errors++; $display("[TB] FAIL write_isolation wr=%0d rd=%0d out=%h expected=%h", i, j, out, model[j]);
                end
            end
        end
    endtask

    task automatic test_read_during_write();
        address = 3'd3;
        in      = 16'hBEEF;
        load    = 1'b1;
        #1;
        checks++;
        if (out !== 16'h4444) begin
            errors++; $display("[TB] FAIL rdw_before out=%h expected=%h", out, 16'h4444);
        end
        tick();
        load = 1'b0;
        checks++;
        if (out !== 16'hBEEF) begin
            errors++; $display("[TB] FAIL rdw_after out=%h expected=%h", out, 16'hBEEF);
        end
    endtask

    task automatic test_sweep();
        fill_all();
        address = 3'd5;
        clear   = 1'b1;
        tick();
        clear   = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL sweep_start busy=%b expected=1", busy);
        end
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (busy !== (k < 8)) begin
                errors++; $display("[TB] FAIL sweep_busy E%0d busy=%b expected=%b", k, busy, k < 8);
            end
            checks++;
            if (done !== (k == 8)) begin
                errors++; $display("[TB] FAIL sweep_done E%0d done=%b expected=%b", k, done, k == 8);
            end
            checks++;
            if (out !== ((k >= 6) ? 16'h0000 : 16'h6666)) begin
                errors++; $display("[TB] FAIL sweep_addr5 E%0d out=%h expected=%h", k, out, (k >= 6) ? 16'h0000 : 16'h6666);
            end
        end
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++; $display("[TB] FAIL sweep_zero addr=%0d out=%h expected=0000", i, out);
            end
        end
    endtask

    task automatic test_sweep_ignores();
        int busy_cycles;
        fill_all();
        address = 3'd7;
        clear   = 1'b1;
        tick();
        clear   = 1'b0;
        busy_cycles = busy ? 1 : 0;
        for (int k = 1; k <= 12; k++) begin
            load  = (k == 2);
            clear = (k == 4);
            in    = (k == 2) ? 16'hFFFF : 16'h0000;
            tick();
            load  = 1'b0;
            clear = 1'b0;
            if (busy) busy_cycles++;
            if (k == 2) begin
                checks++;
                if (out !== 16'h8888) begin
                    errors++; $display("[TB] FAIL sweep_load_ignored out=%h expected=%h", out, 16'h8888);
                end
            end
        end
        checks++;
        if (busy_cycles != 8) begin
            errors++; $display("[TB] FAIL sweep_clear_ignored busy_cycles=%0d expected=8", busy_cycles);
        end
        checks++;
        if (out !== 16'h0000) begin
            errors++; $display("[TB] FAIL sweep_entry7 out=%h expected=0000", out);
        end
    endtask

    task automatic test_load_and_clear();
        int waited;
        address = 3'd4;
        in      = 16'h1234;
        load    = 1'b1;
        clear   = 1'b1;
        tick();
        load    = 1'b0;
        clear   = 1'b0;
        checks++;
        if (out !== 16'h1234 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL load_clear_write out=%h busy=%b expected=1234/1", out, busy);
        end
        waited = 0;
        while (busy && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (busy || waited != 8) begin
            errors++; $display("[TB] FAIL load_clear_sweep waited=%0d busy=%b expected=8/0", waited, busy);
        end
        checks++;
        if (out !== 16'h0000) begin
            errors++; $display("[TB] FAIL load_clear_zeroed out=%h expected=0000", out);
        end
    endtask

    task automatic test_back_to_back();
        int waited;
        clear = 1'b1;
        tick();
        for (int k = 1; k <= 8; k++) tick();
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL b2b_first_done done=%b busy=%b expected=1/0", done, busy);
        end
        tick();
        clear = 1'b0;
        checks++;
        if (done !== 1'b0 || busy !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_restart done=%b busy=%b expected=0/1", done, busy);
        end
        waited = 0;
        while (busy && waited < 20) begin
            tick();
            waited++;
        end
        checks++;
        if (waited != 8 || done !== 1'b1) begin
            errors++; $display("[TB] FAIL b2b_second waited=%0d done=%b expected=8/1", waited, done);
        end
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        int done_seen;
        fill_all();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        tick(); tick();
        #3 reset = 1'b1;
        #1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("[TB] FAIL midsweep_reset busy=%b done=%b expected=0/0", busy, done);
        end
        for (int i = 0; i < 8; i++) begin
            address = 3'(i);
            #1;
            checks++;
            if (out !== 16'h0000) begin
                errors++; $display("[TB] FAIL midsweep_zero addr=%0d out=%h expected=0000", i, out);
            end
        end
        tick();
        #2 reset = 1'b0;
        write_word(3'd2, 16'h00AA);
        address = 3'd2;
        #1;
        checks++;
        if (out !== 16'h00AA || busy !== 1'b0) begin
            errors++; $display("[TB] FAIL post_reset_write out=%h busy=%b expected=00AA/0", out, busy);
        end
        done_seen = 0;
        for (int k = 0; k < 10; k++) begin
            tick();
            if (done) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++; $display("[TB] FAIL post_reset_done pulses=%0d expected=0", done_seen);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_write_read();
        test_read_during_write();
        test_sweep();
        test_sweep_ignores();
        test_load_and_clear();
        test_back_to_back();
        test_reset_mid_sweep();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
